tc_burst_ram_lat: RTL and testbench

//  Multi-lane burst RAM with a parametrised read latency and a per-lane write mask.

---
 rtl/tc_ram_pkg.sv | 24 ++
 rtl/tc_burst_ram_lat_if.sv | 37 +++
 rtl/tc_lat_pipe.sv | 56 +++++
 rtl/tc_burst_ram_lat.sv | 182 ++++++++++++++++++
 tb/tb_tc_burst_ram_lat.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_ram_pkg.sv
// ----------------------------------------------------------------------------
// tc_ram_pkg
// Shared types and helpers for the burst RAM slice.
//   state_t    : clear/idle state of the memory sequencer
//   addr_bits  : address width for a given depth, never less than 1
//   lane_lo    : low bit of lane k inside a flattened multi-lane word
// ----------------------------------------------------------------------------
package tc_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Guards against a zero-width address when the depth is 1.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/tc_burst_ram_lat_if.sv
// ----------------------------------------------------------------------------
// tc_burst_ram_lat_if
// Request/response bundle of the burst RAM.
//   load, save   : read / write request, sampled on posedge
//   address      : base word address (lane k uses address+k)
//   lane_mask    : per-lane write enable
//   in_data      : write data, lane k at [k*BIT_WIDTH +: BIT_WIDTH]
//   busy         : memory clear in progress, requests ignored
//   ready        : one-cycle pulse qualifying out_data
//   out_data     : read data, zero when ready is low
// master drives requests, slave is the RAM.
// ----------------------------------------------------------------------------
interface tc_burst_ram_lat_if #(
    parameter int LANES     = 4,
    parameter int BIT_WIDTH = 16
) ();

    logic                       load;
    logic                       save;
    logic [15:0]                address;
    logic [LANES-1:0]           lane_mask;
    logic [LANES*BIT_WIDTH-1:0] in_data;
    logic                       busy;
    logic                       ready;
    logic [LANES*BIT_WIDTH-1:0] out_data;

    modport master (
        output load, save, address, lane_mask, in_data,
        input  busy, ready, out_data
    );

    modport slave (
        input  load, save, address, lane_mask, in_data,
        output busy, ready, out_data
    );

endinterface

// File: rtl/tc_lat_pipe.sv
// ----------------------------------------------------------------------------
// tc_lat_pipe
// Valid + data shift register of DEPTH stages (DEPTH >= 1).
//   clk, rst  : clock, synchronous active-high reset (clears valid and data)
//   in_vld    : valid entering stage 1
//   in_data   : data entering stage 1
//   out_vld   : valid leaving the last stage
//   out_data  : data leaving the last stage
// ----------------------------------------------------------------------------
module tc_lat_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH < 1) begin : g_err_depth
        $error("tc_lat_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0]            vld_p1;
    logic [DEPTH-1:0][WIDTH-1:0] data_p1;
    logic [DEPTH-1:0]            vld_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] data_nxt;

    always_comb begin
        vld_nxt     = '0;
        data_nxt    = '0;
        vld_nxt[0]  = in_vld;
        data_nxt[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            vld_nxt[i]  = vld_p1[i-1];
            data_nxt[i] = data_p1[i-1];
        end
    end

    // ---- stage boundary: shift register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= vld_nxt;
            data_p1 <= data_nxt;
        end
    end

    assign out_vld  = vld_p1[DEPTH-1];
    assign out_data = data_p1[DEPTH-1];

endmodule

// File: rtl/tc_burst_ram_lat.sv
// ----------------------------------------------------------------------------
// tc_burst_ram_lat
// Multi-lane burst RAM with configurable read latency, per-lane write mask,
// address wrap and a sequenced clear after reset.
//   clk   : clock, all logic on posedge
//   rst   : synchronous active-high reset; restarts the clear sweep
//   bus   : tc_burst_ram_lat_if.slave (load/save/address/lane_mask/in_data in,
//           busy/ready/out_data out)
// The array is split into LANES banks (bank = word mod LANES). Since lanes of
// one access hit consecutive words, every lane lands in a different bank, so
// each bank sees at most one read and one write per cycle.
// ----------------------------------------------------------------------------
module tc_burst_ram_lat
    import tc_ram_pkg::*;
#(
    parameter int    UUID         = 0,
    parameter string NAME         = "",
    parameter int    BIT_WIDTH    = 16,
    parameter int    BIT_DEPTH    = 256,
    parameter int    LANES        = 4,
    parameter int    READ_LATENCY = 2
) (
    input logic               clk,
    input logic               rst,
    tc_burst_ram_lat_if.slave bus
);

    localparam int WORD_W   = LANES * BIT_WIDTH;
    localparam int ROWS     = BIT_DEPTH / LANES;
    localparam int ROW_BITS = addr_bits(ROWS);
    localparam int LANE_W   = addr_bits(LANES);

    if (UUID < 0) begin : g_err_uuid
        $error("%s: UUID must be non-negative", NAME);
    end
    if (LANES < 1) begin : g_err_lanes
        $error("tc_burst_ram_lat: LANES must be at least 1");
    end
    if (READ_LATENCY < 1) begin : g_err_lat
        $error("tc_burst_ram_lat: READ_LATENCY must be at least 1");
    end
    if (BIT_DEPTH < 1 || (BIT_DEPTH & (BIT_DEPTH - 1)) != 0) begin : g_err_depth
        $error("tc_burst_ram_lat: BIT_DEPTH must be a power of two");
    end
    if (LANES > BIT_DEPTH) begin : g_err_overlap
        $error("tc_burst_ram_lat: LANES > BIT_DEPTH would make lanes overlap");
    end
    if ((BIT_DEPTH % LANES) != 0) begin : g_err_mult
        $error("tc_burst_ram_lat: BIT_DEPTH must be a multiple of LANES");
    end

    // ------------------------------------------------------------------
    // Clear sequencer. clr_ptr counts rows; one row spans all banks, so
    // each CLEAR cycle zeroes LANES consecutive words.
    // ------------------------------------------------------------------
    state_t              state, state_nxt;
    logic [ROW_BITS-1:0] clr_ptr, clr_ptr_nxt;
    logic                clr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_we      = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_ptr == ROW_BITS'(ROWS - 1)) begin
                    state_nxt   = IDLE;
                    clr_ptr_nxt = '0;
                end else begin
                    clr_ptr_nxt = clr_ptr + 1'b1;
                end
            end
            IDLE:    state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    assign bus.busy = (state == CLEAR);

    logic accept, rd_en, wr_en;
    assign accept = (state == IDLE) && !rst;
    assign rd_en  = accept && bus.load;
    assign wr_en  = accept && bus.save;

    // ------------------------------------------------------------------
    // Lane/bank routing. Address bits above the depth are dropped, then
    // word (base+k) mod BIT_DEPTH lives in bank (base+k) mod LANES.
    // ------------------------------------------------------------------
    logic [LANE_W-1:0]   bank_lane [LANES];  // lane that addresses bank b
    logic [ROW_BITS-1:0] bank_row  [LANES];  // row touched in bank b
    logic [LANE_W-1:0]   lane_bank [LANES];  // bank that serves lane k

    always_comb begin : p_route
        int base;
        int lk;
        int w;
        base = int'(bus.address) & (BIT_DEPTH - 1);
        lk   = 0;
        w    = 0;
        for (int b = 0; b < LANES; b++) begin
            lk           = (b - base) & (LANES - 1);
            w            = (base + lk) & (BIT_DEPTH - 1);
            bank_lane[b] = LANE_W'(lk);
            bank_row[b]  = ROW_BITS'(w / LANES);
        end
        for (int k = 0; k < LANES; k++) begin
            lane_bank[k] = LANE_W'((base + k) & (LANES - 1));
        end
    end

    logic [BIT_WIDTH-1:0] bank_rd [LANES];

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [BIT_WIDTH-1:0] bank_mem [ROWS];

        always_ff @(posedge clk) begin
            if (clr_we) begin
                bank_mem[clr_ptr] <= '0;
            end else if (wr_en && bus.lane_mask[bank_lane[b]]) begin
                bank_mem[bank_row[b]] <=
                    bus.in_data[lane_lo(int'(bank_lane[b]), BIT_WIDTH) +: BIT_WIDTH];
            end
        end

        // Read is taken from the pre-edge array, so a simultaneous save on
        // the same word returns the old contents.
        assign bank_rd[b] = bank_mem[bank_row[b]];
    end

    logic [WORD_W-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_word[lane_lo(k, BIT_WIDTH) +: BIT_WIDTH] = bank_rd[lane_bank[k]];
        end
    end

    // ---- stage boundary: array read (p0) ----
    logic              vld_p0;
    logic [WORD_W-1:0] rd_data_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            rd_data_p0 <= '0;
        end else begin
            vld_p0     <= rd_en;
            rd_data_p0 <= rd_en ? rd_word : '0;
        end
    end

    // ---- stage boundary: remaining READ_LATENCY-1 stages ----
    if (READ_LATENCY > 1) begin : g_pipe
        tc_lat_pipe #(
            .DEPTH (READ_LATENCY - 1),
            .WIDTH (WORD_W)
        ) u_pipe (
            .clk      (clk),
            .rst      (rst),
            .in_vld   (vld_p0),
            .in_data  (rd_data_p0),
            .out_vld  (bus.ready),
            .out_data (bus.out_data)
        );
    end else begin : g_direct
        assign bus.ready    = vld_p0;
        assign bus.out_data = rd_data_p0;
    end

endmodule

// File: tb/tb_tc_burst_ram_lat.sv
// ----------------------------------------------------------------------------
// tb_tc_burst_ram_lat
// Drives two RAM instances with identical requests:
//   inst 0 : 4 lanes, latency 2, depth 256
//   inst 1 : 1 lane,  latency 1, depth 16
// A word-level reference model (array + list of pending responses) predicts
// busy, ready and out_data every cycle.
// ----------------------------------------------------------------------------
module tb_tc_burst_ram_lat;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tc_burst_ram_lat_if #(.LANES(4), .BIT_WIDTH(16)) bus_a ();
    tc_burst_ram_lat_if #(.LANES(1), .BIT_WIDTH(16)) bus_b ();

    tc_burst_ram_lat #(
        .UUID(1), .NAME("ram_a"), .BIT_WIDTH(16), .BIT_DEPTH(256),
        .LANES(4), .READ_LATENCY(2)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    tc_burst_ram_lat #(
        .UUID(2), .NAME("ram_b"), .BIT_WIDTH(16), .BIT_DEPTH(16),
        .LANES(1), .READ_LATENCY(1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    function automatic int ln(input int i);
        return (i == 0) ? 4 : 1;
    endfunction
    function automatic int lt(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int dp(input int i);
        return (i == 0) ? 256 : 16;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          inst;
        int          due;
        logic [63:0] data;
    } exp_t;

    logic [15:0] mm [2][256];
    int          clr_left [2];
    exp_t        pend [$];
    int          cyc   = 0;
    bit          known = 1'b0;

    logic        obs_rdy_a;
    logic [63:0] obs_dat_a;
    int          rdy_cnt_a = 0;

    function automatic logic [63:0] model_read(input int i, input logic [15:0] ad);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < ln(i); k++)
            r[k*16 +: 16] = mm[i][(int'(ad) + k) % dp(i)];
        return r;
    endfunction

    // One clock cycle: check current outputs, apply inputs, advance model.
    task automatic step(input logic r, input logic ld, input logic sv,
                        input logic [15:0] ad, input logic [3:0] mk, input logic [63:0] dt);
        if (known) begin
            for (int i = 0; i < 2; i++) begin
                logic        o_busy;
                logic        o_rdy;
                logic [63:0] o_dat;
                logic        e_rdy;
                logic [63:0] e_dat;
                o_busy = (i == 0) ? bus_a.busy  : bus_b.busy;
                o_rdy  = (i == 0) ? bus_a.ready : bus_b.ready;
                o_dat  = (i == 0) ? bus_a.out_data : {48'd0, bus_b.out_data};
                e_rdy  = 1'b0;
                e_dat  = '0;
                for (int j = 0; j < pend.size(); j++) begin
                    if (pend[j].inst == i && pend[j].due == cyc) begin
                        e_rdy = 1'b1;
                        e_dat = pend[j].data;
                        pend.delete(j);
                        break;
                    end
                end
                check($sformatf("busy%0d@%0d", i, cyc), 64'(o_busy), 64'(clr_left[i] > 0));
                check($sformatf("ready%0d@%0d", i, cyc), 64'(o_rdy), 64'(e_rdy));
                check($sformatf("data%0d@%0d", i, cyc), o_dat, e_dat);
            end
            obs_rdy_a = bus_a.ready;
            obs_dat_a = bus_a.out_data;
            if (bus_a.ready) rdy_cnt_a++;
        end

        rst             = r;
        bus_a.load      = ld;
        bus_a.save      = sv;
        bus_a.address   = ad;
        bus_a.lane_mask = mk;
        bus_a.in_data   = dt;
        bus_b.load      = ld;
        bus_b.save      = sv;
        bus_b.address   = ad;
        bus_b.lane_mask = mk[0];
        bus_b.in_data   = dt[15:0];

        for (int i = 0; i < 2; i++) begin
            if (r) begin
                for (int j = pend.size() - 1; j >= 0; j--)
                    if (pend[j].inst == i) pend.delete(j);
                clr_left[i] = dp(i) / ln(i);
                for (int w = 0; w < 256; w++) mm[i][w] = '0;
            end else if (clr_left[i] > 0) begin
                clr_left[i]--;
            end else begin
                if (ld) begin
                    exp_t e;
                    e.inst = i;
                    e.due  = cyc + lt(i);
                    e.data = model_read(i, ad);
                    pend.push_back(e);
                end
                if (sv) begin
                    for (int k = 0; k < ln(i); k++)
                        if (mk[k]) mm[i][(int'(ad) + k) % dp(i)] = dt[k*16 +: 16];
                end
            end
        end
        if (r) known = 1'b1;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 64'h0);
    endtask

    task automatic do_load(input logic [15:0] ad);
        step(1'b0, 1'b1, 1'b0, ad, 4'h0, 64'h0);
    endtask

    task automatic do_save(input logic [15:0] ad, input logic [3:0] mk, input logic [63:0] dt);
        step(1'b0, 1'b0, 1'b1, ad, mk, dt);
    endtask

    initial begin
        bus_a.load = 1'b0; bus_a.save = 1'b0; bus_a.address = '0;
        bus_a.lane_mask = '0; bus_a.in_data = '0;
        bus_b.load = 1'b0; bus_b.save = 1'b0; bus_b.address = '0;
        bus_b.lane_mask = '0; bus_b.in_data = '0;
        clr_left[0] = 0;
        clr_left[1] = 0;
        @(posedge clk);
        #1;

        // 1: reset, loads while clearing are dropped
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 64'h0);
        for (int i = 0; i < 50; i++)
            step(1'b0, 1'b1, 1'b0, 16'($urandom), 4'h0, 64'h0);
        idle(20);
        check("t1_no_ready_while_busy", 64'(rdy_cnt_a), 64'd0);

        // 2: basic write/read, ready exactly at N+2
        do_save(16'h0010, 4'hF, 64'h0004_0003_0002_0001);
        do_load(16'h0010);
        idle(1);
        check("t2_not_early", 64'(obs_rdy_a), 64'd0);
        idle(1);
        check("t2_ready", 64'(obs_rdy_a), 64'd1);
        check("t2_data", obs_dat_a, 64'h0004_0003_0002_0001);

        // 3: wrap across the top of the array
        do_save(16'h00FE, 4'hF, 64'h000D_000C_000B_000A);
        do_load(16'h00FE);
        idle(2);
        check("t3_wrap_data", obs_dat_a, 64'h000D_000C_000B_000A);
        do_load(16'hFF00);
        idle(2);
        check("t3_low_words", obs_dat_a, 64'h0000_0000_000D_000C);

        // 4: masked write, then read-before-write on same cycle
        do_save(16'h0010, 4'b0101, 64'h0009_0009_0009_0009);
        do_load(16'h0010);
        idle(2);
        check("t4_mask", obs_dat_a, 64'h0004_0009_0002_0009);
        step(1'b0, 1'b1, 1'b1, 16'h0010, 4'hF, 64'h0007_0007_0007_0007);
        idle(2);
        check("t4_rbw_old", obs_dat_a, 64'h0004_0009_0002_0009);
        do_load(16'h0010);
        idle(2);
        check("t4_new", obs_dat_a, 64'h0007_0007_0007_0007);

        // 5: back-to-back loads
        do_save(16'h0004, 4'hF, 64'h1111_2222_3333_4444);
        do_save(16'h0008, 4'hF, 64'h5555_6666_7777_8888);
        do_load(16'h0000);
        do_load(16'h0004);
        do_load(16'h0008);
        check("t5_first", obs_dat_a, 64'h0000_0000_000D_000C);
        idle(1);
        check("t5_second_rdy", 64'(obs_rdy_a), 64'd1);
        check("t5_second", obs_dat_a, 64'h1111_2222_3333_4444);
        idle(1);
        check("t5_third", obs_dat_a, 64'h5555_6666_7777_8888);
        idle(1);
        check("t5_done", 64'(obs_rdy_a), 64'd0);

        // 6: reset mid-clear, then reset with a load in flight
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 64'h0);
        idle(20);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 64'h0);
        idle(70);
        do_save(16'h0020, 4'hF, 64'hAAAA_BBBB_CCCC_DDDD);
        do_load(16'h0020);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 64'h0);
        idle(1);
        check("t6_flushed", 64'(obs_rdy_a), 64'd0);
        idle(70);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] ad;
            int          sel;
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      ad = 16'(16'h0010 + $urandom_range(0, 7));
            else if (sel == 1) ad = 16'(16'h00FC + $urandom_range(0, 3));
            else               ad = 16'($urandom);
            step(($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom), ad,
                 4'($urandom), {$urandom, $urandom});
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
